fp16_div_seq: RTL and testbench
===============================

Name: fp16_div_seq

Overview:
- Iterative half-precision (1/5/10) floating-point divider; the inverse-operation companion to the pipelined FP16 multiplier.
- Computes result = a / b using radix-2 restoring division of the 11-bit significands. Rounding is round-to-nearest-even.
- Valid/ready handshake on both sides. One operation in flight at a time.
- Sits beside the multiplier in the FP datapath and uses the same 5-bit flags convention.

Parameters:
- EXP_W, 5, exponent width
- MAN_W, 10, stored mantissa width (hidden bit implied)
- BIAS, 15, exponent bias

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operands a, b valid
- in_ready  out  1  divider can accept operands
- a  in  16  dividend, FP16
- b  in  16  divisor, FP16
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  16  quotient, FP16
- flags  out  5  [4] invalid, [3] div-by-zero, [2] overflow, [1] underflow, [0] inexact

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; out_valid=0; result=0; flags=0; all internal registers cleared.
  - in_ready=1, because it is decoded from state==IDLE.
- FSM states and transitions:
  - IDLE: in_ready=1. An accept occurs when in_valid && in_ready. On accept, register a and b and go to PREP.
  - PREP, 1 cycle:
    - Unpack operands. Subnormal inputs are treated as zero (flush-to-zero).
    - Sign = Sa^Sb. Exponent difference = Ea - Eb + BIAS, held as 7-bit signed.
    - Classify special cases and go to DIV.
  - DIV, 14 cycles:
    - Restoring division of {1,Ma} by {1,Mb}, one quotient bit per cycle.
    - 14-bit quotient, MSB first. Iteration counter runs 13→0.
    - Remainder is 12 bits. Sticky = (final remainder != 0).
  - RND, 1 cycle:
    - If q[13]=0: shift left 1 and decrement the exponent.
    - Take 11 significand bits plus guard, round bit, and the OR of the remaining bits with sticky.
    - Apply RNE. A mantissa carry-out increments the exponent.
    - Check exponent range, then load result and flags. Go to DONE.
  - DONE: out_valid=1. When out_ready=1, go to IDLE; out_valid falls on the next edge.
- Latency:
  - Normal operands: out_valid rises on the 17th rising edge after the accept edge.
  - in_ready=0 in every non-IDLE state. A new accept is possible at the earliest 1 cycle after the output handshake.
- Special cases (IEEE), decided in PREP:
  - NaN input, 0/0, or inf/inf → 0x7E00 (canonical qNaN, positive), invalid=1.
  - Finite nonzero / 0 → signed inf, divbyzero=1.
  - inf / finite → signed inf, no flags.
  - Finite / inf → signed zero, no flags.
  - 0 / nonzero finite → signed zero, no flags.
- Range checks in RND:
  - Exponent ≥ 31 → signed inf, overflow=1, inexact=1.
  - Exponent ≤ 0 → signed zero, underflow=1, inexact=1 (no subnormal output).
  - inexact = guard|round|sticky for normal results.
- Output backpressure: result and flags are held stable while out_valid=1 && out_ready=0, for any number of cycles.
- Reset mid-operation: the operation is aborted with no output; returns to IDLE.

Optional Feature:
- Macro: FPDIV_EARLY_SPECIAL_EN
- Defined:
  - Special-case operands skip DIV and RND. PREP goes straight to DONE.
  - out_valid rises on the 2nd edge after accept.
- Undefined:
  - Every operation traverses DIV and RND with the special-case result forced in RND.
  - Latency is a constant 17 cycles for all inputs.

Test Plan:
- 0x3C00 / 0x3C00 (1/1), out_ready=1 → result 0x3C00, flags 0, out_valid exactly 17 cycles after accept, in_ready=0 throughout.
- 0x4600 / 0x4000 (6/2) → 0x4200, flags 0; then 0x3C00 / 0x4200 (1/3) → 0x3555, flags=0x01 (inexact).
- Specials:
  - 0x3C00 / 0x0000 → 0x7C00, flags=0x08.
  - 0x0000 / 0x0000 → 0x7E00, flags=0x10.
  - 0xC000 / 0x7C00 → 0x8000, flags=0.
  - Latency is 2 with FPDIV_EARLY_SPECIAL_EN defined and 17 without.
- 0x7BFF / 0x0400 → 0x7C00, flags=0x05 (overflow, inexact); 0x0400 / 0x7BFF → 0x0000, flags=0x03 (underflow, inexact).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid on 1/3 → result and flags stable at 0x3555/0x01, in_ready=0; raise out_ready → in_ready=1 on the next cycle.
- Drive rst=0 asynchronously mid-DIV (cycle 8) → out_valid=0, result=0, flags=0 immediately, in_ready=1. After release, 1/1 completes normally in 17 cycles.

Source files
------------

// File: rtl/fp16_div_seq.sv
// rtl/fp16_div_seq.sv - iterative FP16 divider: radix-2 restoring significand division, RNE rounding, valid/ready.
// Optional macro FPDIV_EARLY_SPECIAL_EN: special-case operands bypass DIV/RND and finish straight from PREP.
module fp16_div_seq #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int BIAS  = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic [4:0]           flags
);
   localparam int FP_W  = EXP_W + MAN_W + 1;
   localparam int SIG_W = MAN_W + 1;
   localparam int Q_W   = SIG_W + 3;
   localparam int E_W   = EXP_W + 2;
   localparam int CNT_W = $clog2(Q_W);
   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam logic [FP_W-1:0]  QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_RND, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [FP_W-1:0]     r_a;
   logic [FP_W-1:0]     r_b;
   logic                r_sign;
   logic [E_W-1:0]      r_exp;
   logic [SIG_W-1:0]    r_div;
   logic [SIG_W:0]      r_rem;
   logic [Q_W-1:0]      r_q;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_spec;
   logic [FP_W-1:0]     r_spec_res;
   logic [4:0]          r_spec_flags;
   logic [FP_W-1:0]     r_result;
   logic [4:0]          r_flags;

   logic [EXP_W-1:0]    w_ea;
   logic [EXP_W-1:0]    w_eb;
   logic [MAN_W-1:0]    w_ma;
   logic [MAN_W-1:0]    w_mb;
   logic                w_sign;
   logic                w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
   logic                w_spec;
   logic [FP_W-1:0]     w_spec_res;
   logic [4:0]          w_spec_flags;

   logic                w_ge;
   logic [SIG_W-1:0]    w_rem_sub;
   logic [SIG_W:0]      w_rem_nxt;

   logic [Q_W-1:0]      w_norm_q;
   logic [E_W-1:0]      w_exp_n;
   logic [SIG_W-1:0]    w_sig;
   logic                w_g, w_r, w_s, w_rnd_up, w_inexact;
   logic [SIG_W:0]      w_sig_rnd;
   logic [E_W-1:0]      w_exp_r;
   logic [MAN_W-1:0]    w_man;
   logic                w_ovf, w_unf;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign result    = r_result;
   assign flags     = r_flags;

   // Operand unpack; a zero exponent field (zero or subnormal) is treated as zero.
   assign w_ea     = r_a[FP_W-2:MAN_W];
   assign w_eb     = r_b[FP_W-2:MAN_W];
   assign w_ma     = r_a[MAN_W-1:0];
   assign w_mb     = r_b[MAN_W-1:0];
   assign w_sign   = r_a[FP_W-1] ^ r_b[FP_W-1];
   assign w_a_zero = (w_ea == '0);
   assign w_b_zero = (w_eb == '0);
   assign w_a_inf  = (w_ea == EXP_MAX) && (w_ma == '0);
   assign w_b_inf  = (w_eb == EXP_MAX) && (w_mb == '0);
   assign w_a_nan  = (w_ea == EXP_MAX) && (w_ma != '0);
   assign w_b_nan  = (w_eb == EXP_MAX) && (w_mb != '0);

   always_comb begin
      w_spec       = 1'b1;
      w_spec_res   = '0;
      w_spec_flags = '0;
      if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
         w_spec_res   = QNAN;
         w_spec_flags = 5'b10000;
      end else if (w_a_inf) begin
         w_spec_res = {w_sign, EXP_MAX, {MAN_W{1'b0}}};
      end else if (w_b_zero) begin
         w_spec_res   = {w_sign, EXP_MAX, {MAN_W{1'b0}}};
         w_spec_flags = 5'b01000;
      end else if (w_b_inf || w_a_zero) begin
         w_spec_res = {w_sign, {(FP_W-1){1'b0}}};
      end else begin
         w_spec = 1'b0;
      end
   end

   // The partial remainder stays below 2*divisor, so only its low SIG_W bits matter after a subtract.
   assign w_ge      = (r_rem >= {1'b0, r_div});
   assign w_rem_sub = r_rem[SIG_W-1:0] - r_div;
   assign w_rem_nxt = w_ge ? {w_rem_sub, 1'b0} : {r_rem[SIG_W-1:0], 1'b0};

   assign w_norm_q  = r_q[Q_W-1] ? r_q : {r_q[Q_W-2:0], 1'b0};
   assign w_exp_n   = r_q[Q_W-1] ? r_exp : r_exp - E_W'(1);
   assign w_sig     = w_norm_q[Q_W-1:3];
   assign w_g       = w_norm_q[2];
   assign w_r       = w_norm_q[1];
   assign w_s       = w_norm_q[0] | (r_rem != '0);
   assign w_rnd_up  = w_g & (w_r | w_s | w_sig[0]);
   assign w_inexact = w_g | w_r | w_s;
   assign w_sig_rnd = {1'b0, w_sig} + {{SIG_W{1'b0}}, w_rnd_up};
   assign w_exp_r   = w_exp_n + {{(E_W-1){1'b0}}, w_sig_rnd[SIG_W]};
   assign w_man     = w_sig_rnd[SIG_W] ? w_sig_rnd[SIG_W-1:1] : w_sig_rnd[MAN_W-1:0];
   assign w_ovf     = !w_exp_r[E_W-1] && (w_exp_r[E_W-2:0] >= {1'b0, EXP_MAX});
   assign w_unf     = w_exp_r[E_W-1] || (w_exp_r == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (in_valid) w_state_nxt = S_PREP;
`ifdef FPDIV_EARLY_SPECIAL_EN
         S_PREP: w_state_nxt = w_spec ? S_DONE : S_DIV;
`else
         S_PREP: w_state_nxt = S_DIV;
`endif
         S_DIV:  if (r_cnt == '0) w_state_nxt = S_RND;
         S_RND:  w_state_nxt = S_DONE;
         S_DONE: if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a          <= '0;
         r_b          <= '0;
         r_sign       <= 1'b0;
         r_exp        <= '0;
         r_div        <= '0;
         r_rem        <= '0;
         r_q          <= '0;
         r_cnt        <= '0;
         r_spec       <= 1'b0;
         r_spec_res   <= '0;
         r_spec_flags <= '0;
         r_result     <= '0;
         r_flags      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a <= a;
                  r_b <= b;
               end
            end
            S_PREP: begin
               r_sign       <= w_sign;
               r_exp        <= {2'b00, w_ea} - {2'b00, w_eb} + E_W'(BIAS);
               r_rem        <= {2'b01, w_ma};
               r_div        <= {1'b1, w_mb};
               r_q          <= '0;
               r_cnt        <= CNT_W'(Q_W - 1);
               r_spec       <= w_spec;
               r_spec_res   <= w_spec_res;
               r_spec_flags <= w_spec_flags;
`ifdef FPDIV_EARLY_SPECIAL_EN
               if (w_spec) begin
                  r_result <= w_spec_res;
                  r_flags  <= w_spec_flags;
               end
`endif
            end
            S_DIV: begin
               r_q   <= {r_q[Q_W-2:0], w_ge};
               r_rem <= w_rem_nxt;
               r_cnt <= r_cnt - CNT_W'(1);
            end
            S_RND: begin
               if (r_spec) begin
                  r_result <= r_spec_res;
                  r_flags  <= r_spec_flags;
               end else if (w_ovf) begin
                  r_result <= {r_sign, EXP_MAX, {MAN_W{1'b0}}};
                  r_flags  <= 5'b00101;
               end else if (w_unf) begin
                  r_result <= {r_sign, {(FP_W-1){1'b0}}};
                  r_flags  <= 5'b00011;
               end else begin
                  r_result <= {r_sign, w_exp_r[EXP_W-1:0], w_man};
                  r_flags  <= {4'b0000, w_inexact};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_div_seq.sv
// tb/tb_fp16_div_seq.sv - directed self-checking bench for fp16_div_seq.
// Latency is counted in rising edges with the accept edge as edge 1.
module tb_fp16_div_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [4:0]  flags;

   int total = 0;
   int bad   = 0;

`ifdef FPDIV_EARLY_SPECIAL_EN
   localparam int SPEC_LAT = 2;
`else
   localparam int SPEC_LAT = 17;
`endif

   always #5 clk = ~clk;

   fp16_div_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   // Issues one operation and waits (bounded) for out_valid; lat=-1 on timeout.
   task automatic do_op(input logic [15:0] va, input logic [15:0] vb, output int lat, output bit busy_ok);
      int c;
      busy_ok = 1'b1;
      @(negedge clk);
      a        = va;
      b        = vb;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      c = 1;
      while (!out_valid && c < 40) begin
         if (in_ready !== 1'b0) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         c++;
      end
      lat = out_valid ? c : -1;
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result: got %h want 0000", result); end
      total++; if (flags !== 5'h00) begin bad++; $display("FAIL reset_flags: got %h want 00", flags); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_one_by_one();
      int lat;
      bit busy_ok;
      do_op(16'h3C00, 16'h3C00, lat, busy_ok);
      total++; if (result !== 16'h3C00) begin bad++; $display("FAIL one_result: got %h want 3c00", result); end
      total++; if (flags !== 5'h00) begin bad++; $display("FAIL one_flags: got %h want 00", flags); end
      total++; if (lat !== 17) begin bad++; $display("FAIL one_latency: got %0d want 17", lat); end
      total++; if (busy_ok !== 1'b1) begin bad++; $display("FAIL one_in_ready_busy: got %b want 1", busy_ok); end
      @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL one_out_valid_drop: got %b want 0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL one_in_ready_back: got %b want 1", in_ready); end
   endtask

   task automatic test_divide();
      int lat;
      bit busy_ok;
      do_op(16'h4600, 16'h4000, lat, busy_ok);
      total++; if (result !== 16'h4200) begin bad++; $display("FAIL six_by_two_result: got %h want 4200", result); end
      total++; if (flags !== 5'h00) begin bad++; $display("FAIL six_by_two_flags: got %h want 00", flags); end
      total++; if (lat !== 17) begin bad++; $display("FAIL six_by_two_latency: got %0d want 17", lat); end
      @(posedge clk);
      #1;
      do_op(16'h3C00, 16'h4200, lat, busy_ok);
      total++; if (result !== 16'h3555) begin bad++; $display("FAIL third_result: got %h want 3555", result); end
      total++; if (flags !== 5'h01) begin bad++; $display("FAIL third_flags: got %h want 01", flags); end
      total++; if (lat !== 17) begin bad++; $display("FAIL third_latency: got %0d want 17", lat); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_specials();
      int lat;
      bit busy_ok;
      logic [15:0] va, vb, er;
      logic [4:0]  ef;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       begin va = 16'h3C00; vb = 16'h0000; er = 16'h7C00; ef = 5'h08; end
            1:       begin va = 16'h0000; vb = 16'h0000; er = 16'h7E00; ef = 5'h10; end
            default: begin va = 16'hC000; vb = 16'h7C00; er = 16'h8000; ef = 5'h00; end
         endcase
         do_op(va, vb, lat, busy_ok);
         total++; if (result !== er) begin bad++; $display("FAIL special%0d_result: got %h want %h", i, result, er); end
         total++; if (flags !== ef) begin bad++; $display("FAIL special%0d_flags: got %h want %h", i, flags, ef); end
         total++; if (lat !== SPEC_LAT) begin bad++; $display("FAIL special%0d_latency: got %0d want %0d", i, lat, SPEC_LAT); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_range();
      int lat;
      bit busy_ok;
      logic [15:0] va, vb, er;
      logic [4:0]  ef;
      for (int i = 0; i < 2; i++) begin
         if (i == 0) begin va = 16'h7BFF; vb = 16'h0400; er = 16'h7C00; ef = 5'h05; end
         else        begin va = 16'h0400; vb = 16'h7BFF; er = 16'h0000; ef = 5'h03; end
         do_op(va, vb, lat, busy_ok);
         total++; if (result !== er) begin bad++; $display("FAIL range%0d_result: got %h want %h", i, result, er); end
         total++; if (flags !== ef) begin bad++; $display("FAIL range%0d_flags: got %h want %h", i, flags, ef); end
         total++; if (lat !== 17) begin bad++; $display("FAIL range%0d_latency: got %0d want 17", i, lat); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bit busy_ok;
      out_ready = 1'b0;
      do_op(16'h3C00, 16'h4200, lat, busy_ok);
      total++; if (lat !== 17) begin bad++; $display("FAIL bp_latency: got %0d want 17", lat); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp%0d_out_valid: got %b want 1", i, out_valid); end
         total++; if (result !== 16'h3555) begin bad++; $display("FAIL bp%0d_result: got %h want 3555", i, result); end
         total++; if (flags !== 5'h01) begin bad++; $display("FAIL bp%0d_flags: got %h want 01", i, flags); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp%0d_in_ready: got %b want 0", i, in_ready); end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_reset_mid_op();
      int lat;
      bit busy_ok;
      @(negedge clk);
      a        = 16'h3C00;
      b        = 16'h3C00;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
      total++; if (result !== 16'h0000) begin bad++; $display("FAIL midrst_result: got %h want 0000", result); end
      total++; if (flags !== 5'h00) begin bad++; $display("FAIL midrst_flags: got %h want 00", flags); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
      @(negedge clk);
      rst = 1'b1;
      do_op(16'h3C00, 16'h3C00, lat, busy_ok);
      total++; if (result !== 16'h3C00) begin bad++; $display("FAIL after_rst_result: got %h want 3c00", result); end
      total++; if (flags !== 5'h00) begin bad++; $display("FAIL after_rst_flags: got %h want 00", flags); end
      total++; if (lat !== 17) begin bad++; $display("FAIL after_rst_latency: got %0d want 17", lat); end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_one_by_one();
      test_divide();
      test_specials();
      test_range();
      test_backpressure();
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
